// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU frame controller: opcode values,
// FSM state encoding, default error response and opcode validation.
package uart_alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;

  localparam logic [7:0] DEF_ERR_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

  // Whole opcode byte must match; nonzero upper bits make it invalid.
  function automatic logic is_valid_op(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_frame_timer.sv
// Inter-byte idle timer: counts enabled cycles and flags the cycle in which
// the count has reached TIMEOUT_CYC-1 while still enabled.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned   TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance while enabled and wrap at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame controller: pops opcode/A/B from the RX FIFO, drives an external
// combinational ALU, and pushes one response byte per frame to the TX FIFO.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned     DBIT        = 8,
  parameter int unsigned     NB_OP       = 6,
  parameter int unsigned     TIMEOUT_CYC = 65535,
  parameter logic [DBIT-1:0] ERR_BYTE    = DEF_ERR_BYTE
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_rx_empty,
  input  logic [DBIT-1:0]  i_r_data,
  output logic             o_rd_uart,
  input  logic             i_tx_full,
  output logic             o_wr_uart,
  output logic [DBIT-1:0]  o_w_data,
  output logic [DBIT-1:0]  o_alu_a,
  output logic [DBIT-1:0]  o_alu_b,
  output logic [NB_OP-1:0] o_alu_op,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic             o_busy,
  output logic             o_frame_err,
  output logic             o_op_err
);

  state_t          state_q;
  logic [DBIT-1:0] op_q, a_q, b_q, res_q;
  logic            err_q;
  logic            waiting;
  logic            tmo;

  assign waiting = (state_q == ST_GET_A) || (state_q == ST_GET_B);

  frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .clear_i   (!waiting || !i_rx_empty),
    .enable_i  (waiting && i_rx_empty),
    .expired_o (tmo)
  );

  // Strobes are gated by reset so every output is low while reset is held.
  assign o_rd_uart   = !i_reset && !i_rx_empty &&
                       ((state_q == ST_IDLE) || waiting);
  assign o_wr_uart   = !i_reset && (state_q == ST_SEND) && !i_tx_full;
  assign o_frame_err = !i_reset && tmo;
  assign o_op_err    = o_wr_uart && err_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_w_data    = res_q;
  assign o_alu_a     = a_q;
  assign o_alu_b     = b_q;
  assign o_alu_op    = op_q[NB_OP-1:0];

  // Frame FSM with operand/result capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!i_rx_empty) begin
            op_q    <= i_r_data;
            state_q <= ST_GET_A;
          end
        end
        ST_GET_A: begin
          if (!i_rx_empty) begin
            a_q     <= i_r_data;
            state_q <= ST_GET_B;
          end else if (tmo) begin
            state_q <= ST_IDLE;
          end
        end
        ST_GET_B: begin
          if (!i_rx_empty) begin
            b_q     <= i_r_data;
            state_q <= ST_EXEC;
          end else if (tmo) begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (is_valid_op(8'(op_q))) begin
            res_q <= i_alu_result;
            err_q <= 1'b0;
          end else begin
            res_q <= ERR_BYTE;
            err_q <= 1'b1;
          end
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (!i_tx_full) begin
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: RX FIFO and ALU models, a response scoreboard
// checked every cycle, and directed frame/timing scenarios.
module tb_uart_alu_ctrl;

  localparam int unsigned TMO = 16;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx_empty;
  logic [7:0] i_r_data;
  logic       o_rd_uart;
  logic       i_tx_full;
  logic       o_wr_uart;
  logic [7:0] o_w_data;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_op_err;

  int total = 0;
  int bad   = 0;

  uart_alu_ctrl #(
    .DBIT(8), .NB_OP(6), .TIMEOUT_CYC(TMO), .ERR_BYTE(8'hFF)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
    .i_tx_full(i_tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .o_busy(o_busy),
    .o_frame_err(o_frame_err), .o_op_err(o_op_err)
  );

  always #5 i_clk = ~i_clk;

  // RX FIFO model
  logic [7:0]  rxmem [0:255];
  int unsigned rx_wr = 0;
  int unsigned rx_rd = 0;
  assign i_rx_empty = (rx_wr == rx_rd);
  assign i_r_data   = rxmem[rx_rd[7:0]];
  always @(posedge i_clk) if (o_rd_uart) rx_rd <= rx_rd + 1;

  // External ALU model (sees only the 6-bit opcode)
  always_comb begin
    case (o_alu_op)
      6'h20:   i_alu_result = o_alu_a + o_alu_b;
      6'h22:   i_alu_result = o_alu_a - o_alu_b;
      6'h24:   i_alu_result = o_alu_a & o_alu_b;
      6'h25:   i_alu_result = o_alu_a | o_alu_b;
      6'h26:   i_alu_result = o_alu_a ^ o_alu_b;
      6'h27:   i_alu_result = ~(o_alu_a | o_alu_b);
      6'h03:   i_alu_result = 8'($signed(o_alu_a) >>> o_alu_b);
      6'h02:   i_alu_result = o_alu_a >> o_alu_b;
      default: i_alu_result = 8'h00;
    endcase
  end

  // Frame-level response model: {op_err, byte}
  function automatic logic [8:0] model(input logic [7:0] op, a, b);
    logic [7:0] t;
    case (op)
      8'h20: t = a + b;
      8'h22: t = a - b;
      8'h24: t = a & b;
      8'h25: t = a | b;
      8'h26: t = a ^ b;
      8'h27: t = ~(a | b);
      8'h03: t = 8'($signed(a) >>> b);
      8'h02: t = a >> b;
      default: return {1'b1, 8'hFF};
    endcase
    return {1'b0, t};
  endfunction

  logic [8:0]  exp_mem [0:63];
  int unsigned exp_wr = 0;
  int unsigned exp_rd = 0;
  logic [7:0]  last_data = 8'h00;
  int unsigned pop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    rxmem[rx_wr[7:0]] = d;
    rx_wr = rx_wr + 1;
  endtask

  task automatic expect_resp(input logic [7:0] op, a, b);
    exp_mem[exp_wr[5:0]] = model(op, a, b);
    exp_wr = exp_wr + 1;
  endtask

  // Per-cycle compare against the scoreboard
  task automatic monitor();
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        chk("rd_when_empty", 64'(o_rd_uart && i_rx_empty), 0);
        chk("wr_when_full", 64'(o_wr_uart && i_tx_full), 0);
        if (o_rd_uart) pop_cnt++;
        if (o_wr_uart) begin
          chk("push_pending", 64'(exp_rd != exp_wr), 1);
          if (exp_rd != exp_wr) begin
            chk("resp_data", 64'(o_w_data), 64'(exp_mem[exp_rd[5:0]][7:0]));
            chk("resp_op_err", 64'(o_op_err), 64'(exp_mem[exp_rd[5:0]][8]));
            exp_rd = exp_rd + 1;
          end
          last_data = o_w_data;
        end else begin
          chk("op_err_no_push", 64'(o_op_err), 0);
        end
      end
    end
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((exp_rd != exp_wr || o_busy) && n < 80) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_done"}, 64'(exp_rd == exp_wr && !o_busy), 1);
  endtask

  task automatic run_frame(input string name, input logic [7:0] op, a, b,
                           input logic [7:0] lit);
    int unsigned p0;
    @(posedge i_clk); #1;
    p0 = pop_cnt;
    expect_resp(op, a, b);
    push_byte(op); push_byte(a); push_byte(b);
    wait_drained(name);
    chk({name, "_lit"}, 64'(last_data), 64'(lit));
    chk({name, "_pops"}, 64'(pop_cnt - p0), 3);
  endtask

  // B arrives in cycle n (opcode popped in cycle 0, A in cycle 1)
  task automatic late_b(input string name, input int n, input logic [7:0] b,
                        input logic [7:0] lit);
    @(posedge i_clk); #1;
    expect_resp(8'h20, 8'h07, b);
    push_byte(8'h20); push_byte(8'h07);
    for (int c = 0; c <= n; c++) begin
      @(negedge i_clk);
      if (c >= 2) chk({name, "_no_ferr"}, 64'(o_frame_err), 0);
      if (c == n - 1) begin
        @(posedge i_clk); #1;
        push_byte(b);
      end
    end
    chk({name, "_b_pop"}, 64'(o_rd_uart), 1);
    wait_drained(name);
    chk({name, "_lit"}, 64'(last_data), 64'(lit));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_rd_uart, o_wr_uart, o_busy, o_frame_err, o_op_err,
                o_w_data, o_alu_a, o_alu_b, o_alu_op});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    i_reset   = 1'b1;
    i_tx_full = 1'b0;
    #12;
    chk("reset_outputs", all_outs(), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // Latency and per-cycle strobes for a preloaded ADD frame
    @(posedge i_clk); #1;
    expect_resp(8'h20, 8'h05, 8'h03);
    push_byte(8'h20); push_byte(8'h05); push_byte(8'h03);
    for (int c = 0; c <= 5; c++) begin
      @(negedge i_clk);
      case (c)
        0, 1, 2: begin
          chk("t1_pop", 64'(o_rd_uart), 1);
          chk("t1_no_push", 64'(o_wr_uart), 0);
        end
        3: begin
          chk("t1_exec_no_pop", 64'(o_rd_uart), 0);
          chk("t1_exec_op", 64'(o_alu_op), 64'(6'h20));
          chk("t1_exec_ab", 64'({o_alu_a, o_alu_b}), 64'(16'h0503));
        end
        4: begin
          chk("t1_push", 64'(o_wr_uart), 1);
          chk("t1_data", 64'(o_w_data), 64'(8'h08));
        end
        default: begin
          chk("t1_idle_busy", 64'(o_busy), 0);
          chk("t1_idle_no_push", 64'(o_wr_uart), 0);
        end
      endcase
    end
    wait_drained("t1");

    run_frame("sub_wrap", 8'h22, 8'h03, 8'h05, 8'hFE);
    run_frame("sra",      8'h03, 8'h80, 8'h02, 8'hE0);
    run_frame("or",       8'h25, 8'hA0, 8'h0F, 8'hAF);
    run_frame("nor",      8'h27, 8'h0F, 8'hF0, 8'h00);
    run_frame("xor",      8'h26, 8'hFF, 8'h0F, 8'hF0);
    run_frame("srl",      8'h02, 8'h80, 8'h03, 8'h10);
    run_frame("add_wrap", 8'h20, 8'hFF, 8'h02, 8'h01);
    run_frame("bad_op",   8'h11, 8'h01, 8'h02, 8'hFF);
    run_frame("bad_top",  8'hE0, 8'h01, 8'h02, 8'hFF);
    run_frame("after_bad", 8'h20, 8'h01, 8'h02, 8'h03);

    // Timeout: opcode in cycle 0, A in cycle 1, abort in cycle 17
    @(posedge i_clk); #1;
    push_byte(8'h20); push_byte(8'h07);
    for (int c = 0; c <= 18; c++) begin
      @(negedge i_clk);
      if (c == 1) chk("tmo_a_pop", 64'(o_rd_uart), 1);
      if (c >= 2 && c <= 16) chk("tmo_early", 64'(o_frame_err), 0);
      if (c == 17) begin
        chk("tmo_pulse", 64'(o_frame_err), 1);
        chk("tmo_no_push", 64'(o_wr_uart), 0);
      end
      if (c == 18) begin
        chk("tmo_idle", 64'(o_busy), 0);
        chk("tmo_single", 64'(o_frame_err), 0);
      end
    end
    run_frame("after_tmo", 8'h20, 8'h01, 8'h01, 8'h02);

    late_b("late15", 16, 8'h01, 8'h08);
    late_b("late16", 17, 8'h02, 8'h09);

    // TX back-pressure held for 20 cycles in SEND
    @(posedge i_clk); #1;
    i_tx_full = 1'b1;
    expect_resp(8'h26, 8'h55, 8'h0F);
    push_byte(8'h26); push_byte(8'h55); push_byte(8'h0F);
    for (int c = 0; c <= 23; c++) begin
      @(negedge i_clk);
      if (c >= 4) begin
        chk("full_no_push", 64'(o_wr_uart), 0);
        chk("full_data", 64'(o_w_data), 64'(8'h5A));
        chk("full_busy", 64'(o_busy), 1);
      end
    end
    @(posedge i_clk); #1;
    i_tx_full = 1'b0;
    @(negedge i_clk);
    chk("full_release_push", 64'(o_wr_uart), 1);
    wait_drained("full");
    run_frame("after_full", 8'h20, 8'h10, 8'h20, 8'h30);

    // Reset while waiting for B
    @(posedge i_clk); #1;
    push_byte(8'h20); push_byte(8'h05);
    for (int c = 0; c <= 2; c++) @(negedge i_clk);
    chk("rst_in_getb", 64'(o_busy), 1);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    #1;
    chk("rst_mid_outputs", all_outs(), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_released_idle", 64'(o_busy), 0);
    run_frame("after_rst", 8'h24, 8'hF0, 8'h3C, 8'h30);

    repeat (3) @(negedge i_clk);
    chk("all_responses", 64'(exp_wr - exp_rd), 0);
    chk("rx_drained", 64'(rx_wr - rx_rd), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
